fsm: RTL and testbench
======================

// Module: fsm
//
// PURPOSE
//   Request/acknowledge bus-transaction controller. A 3-state Moore FSM
//   (IDLE/READ/WRITE) accepts a request with a direction bit, holds the
//   active phase until the target acknowledges, then returns to IDLE.
//   Sits between a simple requester and a memory/peripheral port.
//   Outputs are one-hot status flags that drive the downstream datapath enables.
//
// PARAMETERS
//   TIMEOUT_CYCLES  16  max cycles in READ/WRITE without ack (used only with FSM_TIMEOUT_EN); legal range >=1
//
// PORTS
//   clk      in   1  clock; all state updates on rising edge
//   resetn   in   1  reset; synchronous, active-high (1 = reset)
//   req      in   1  transaction request, sampled in IDLE
//   we       in   1  direction with req: 1 = write, 0 = read
//   ack      in   1  target acknowledge, sampled in READ/WRITE
//   idle     out  1  1 while in IDLE
//   read     out  1  1 while in READ
//   write    out  1  1 while in WRITE
//   timeout  out  1  1-cycle pulse on timeout abort; constant 0 without FSM_TIMEOUT_EN
//
// BEHAVIOUR
//   - Moore machine; outputs decoded purely from state; {idle,read,write} always one-hot.
//   - Reset: resetn==1 at a clk edge -> state IDLE; outputs {idle,read,write}=100, timeout=0.
//     Reset mid-transaction aborts to IDLE on that edge; no timeout pulse.
//   - IDLE : req=1,we=0 -> READ; req=1,we=1 -> WRITE; req=0 -> stay. ack ignored.
//   - READ : ack=1 -> IDLE; else stay. req/we ignored (no re-targeting).
//   - WRITE: ack=1 -> IDLE; else stay. req/we ignored.
//   - Latency: inputs sampled at edge N; new state and outputs visible after edge N.
//     Request to active phase takes 1 cycle; ack to IDLE takes 1 cycle.
//   - No back-to-back chaining: READ/WRITE always passes through IDLE for >=1 cycle,
//     even if req is held high with ack.
//   - Simultaneous req and ack in READ/WRITE: ack wins -> IDLE.
//   - Illegal or unreachable state encoding -> IDLE on the next edge (default branch).
//
// CONFIGURATION
//   FSM_TIMEOUT_EN defined:
//     - A cycle counter clears on entry to READ/WRITE and increments each cycle there without ack.
//     - When TIMEOUT_CYCLES consecutive cycles pass without ack: state -> IDLE and timeout=1
//       for exactly one cycle, coincident with the first IDLE cycle.
//     - If ack arrives on the expiring cycle, the transition is a normal ack: timeout stays 0.
//   FSM_TIMEOUT_EN undefined:
//     - No counter. READ/WRITE wait indefinitely for ack. timeout tied to 0.
//
// STRUCTURE
//   - fsm_pkg: typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE} fsm_state_t;
//     localparam for the one-hot output encodings (OUT_IDLE=3'b100, OUT_READ=3'b010,
//     OUT_WRITE=3'b001).
//   - Sub-module fsm_timer (only with FSM_TIMEOUT_EN): inputs clr, en, clk, resetn;
//     output expired; width $clog2(TIMEOUT_CYCLES+1).
//   - fsm: state register, next-state logic, output decode.
//
// TESTING
//   1. Reset, inputs 0 -> {idle,read,write}=100 on the first cycle after reset release.
//   2. IDLE, req=1 we=0 ack=0, wait 2 clk -> 010. Then req=0 ack=1, wait 2 clk -> 100.
//   3. IDLE, req=1 we=1, wait 2 clk -> 001. Hold ack=0 for 5 clk -> stays 001.
//      Then ack=1 -> 100.
//   4. In READ, req=1 ack=1 held -> 100 for one cycle, then 010 (passes through IDLE).
//   5. Assert resetn=1 during WRITE -> 100 after that edge; timeout stays 0.
//   6. FSM_TIMEOUT_EN, TIMEOUT_CYCLES=4: enter READ with ack=0 -> after 4 cycles in READ,
//      outputs 100 and a single-cycle timeout pulse.

Source files
------------

// File: rtl/fsm_pkg.sv
// rtl/fsm_pkg.sv - state type, one-hot status encodings and decode helper for fsm
package fsm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } fsm_state_t;

  // {idle, read, write} status flags
  localparam logic [2:0] OUT_IDLE  = 3'b100;
  localparam logic [2:0] OUT_READ  = 3'b010;
  localparam logic [2:0] OUT_WRITE = 3'b001;

  // Status flags shown while sitting in a given state; unknown encodings read as idle
  function automatic logic [2:0] decode_flags(input fsm_state_t s);
    case (s)
      ST_READ:  decode_flags = OUT_READ;
      ST_WRITE: decode_flags = OUT_WRITE;
      default:  decode_flags = OUT_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/fsm_timer.sv
// rtl/fsm_timer.sv - no-ack cycle counter for the active phase (built only with FSM_TIMEOUT_EN)
module fsm_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int          W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt;

  // cnt holds the number of completed no-ack cycles in the current phase
  always_ff @(posedge clk) begin
    if (resetn || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  // the current no-ack cycle is the TIMEOUT_CYCLES-th one
  assign expired = en && (cnt == LAST);

endmodule

// File: rtl/fsm.sv
// rtl/fsm.sv - req/ack bus-transaction controller (IDLE/READ/WRITE); FSM_TIMEOUT_EN adds the ack timeout abort
module fsm
  import fsm_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic req,
  input  logic we,
  input  logic ack,
  output logic idle,
  output logic read,
  output logic write,
  output logic timeout
);

  fsm_state_t state;
  logic [2:0] flags;
  logic       expired;
  logic       busy;

  assign busy = (state == ST_READ) || (state == ST_WRITE);

  // Elaboration guard: the timer cannot represent a zero-cycle limit
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("fsm: TIMEOUT_CYCLES must be >= 1");
  end

`ifdef FSM_TIMEOUT_EN
  fsm_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .resetn  (resetn),
    .clr     (!busy),
    .en      (busy && !ack),
    .expired (expired)
  );
`else
  assign expired = 1'b0;
`endif

  // State register with registered one-hot flags and the timeout pulse
  always_ff @(posedge clk) begin
    if (resetn) begin
      state   <= ST_IDLE;
      flags   <= OUT_IDLE;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req && we) begin
            state <= ST_WRITE;
            flags <= decode_flags(ST_WRITE);
          end else if (req) begin
            state <= ST_READ;
            flags <= decode_flags(ST_READ);
          end else begin
            state <= ST_IDLE;
            flags <= decode_flags(ST_IDLE);
          end
        end
        ST_READ, ST_WRITE: begin
          // ack takes priority, so an ack on the expiring cycle is a normal finish
          if (ack) begin
            state <= ST_IDLE;
            flags <= decode_flags(ST_IDLE);
          end else if (expired) begin
            state   <= ST_IDLE;
            flags   <= decode_flags(ST_IDLE);
            timeout <= 1'b1;
          end else begin
            state <= state;
            flags <= decode_flags(state);
          end
        end
        default: begin
          state <= ST_IDLE;
          flags <= decode_flags(ST_IDLE);
        end
      endcase
    end
  end

  assign {idle, read, write} = flags;

endmodule

// File: tb/tb_fsm.sv
// tb/tb_fsm.sv - directed and randomized self-checking bench for fsm against a transaction-level model
module tb_fsm;

`ifdef FSM_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  localparam int T = 4;

  logic clk = 1'b0;
  logic resetn, req, we, ack;
  logic idle, read, write, timeout;

  int n_cmp = 0;
  int n_bad = 0;

  // transaction-level reference: is a transfer open, which direction, how long waited
  bit m_busy = 1'b0;
  bit m_dir  = 1'b0;
  int m_wait = 0;
  bit m_tmo  = 1'b0;

  fsm #(.TIMEOUT_CYCLES(T)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .req     (req),
    .we      (we),
    .ack     (ack),
    .idle    (idle),
    .read    (read),
    .write   (write),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] model_flags();
    return {!m_busy, m_busy && !m_dir, m_busy && m_dir};
  endfunction

  task automatic model_edge(input bit r, input bit q, input bit w, input bit a);
    m_tmo = 1'b0;
    if (r) begin
      m_busy = 1'b0;
    end else if (!m_busy) begin
      if (q) begin
        m_busy = 1'b1;
        m_dir  = w;
        m_wait = 0;
      end
    end else if (a) begin
      m_busy = 1'b0;
    end else if (TMO_EN && (m_wait + 1 == T)) begin
      m_busy = 1'b0;
      m_tmo  = 1'b1;
    end else begin
      m_wait++;
    end
  endtask

  // one clock: drive at negedge, update model at the edge, compare just after
  task automatic step(input string tag, input bit r, input bit q, input bit w, input bit a);
    @(negedge clk);
    resetn = r; req = q; we = w; ack = a;
    @(posedge clk);
    model_edge(r, q, w, a);
    #1;
    check({tag, ".flags"}, {idle, read, write}, model_flags());
    check({tag, ".timeout"}, timeout, m_tmo);
  endtask

  initial begin
    resetn = 1'b1; req = 1'b0; we = 1'b0; ack = 1'b0;

    // 1: reset and release
    step("rst0", 1, 0, 0, 0);
    step("rst1", 1, 0, 0, 0);
    check("rst.lit", {idle, read, write}, 3'b100);
    step("rel", 0, 0, 0, 0);
    check("rel.lit", {idle, read, write}, 3'b100);

    // 2: read then ack
    step("rd0", 0, 1, 0, 0);
    step("rd1", 0, 1, 0, 0);
    check("rd.lit", {idle, read, write}, 3'b010);
    step("rdack", 0, 0, 0, 1);
    check("rdack.lit", {idle, read, write}, 3'b100);
    step("rdidle", 0, 0, 0, 1);

    // 3: write, hold without ack, then ack
    step("wr0", 0, 1, 1, 0);
    check("wr.lit", {idle, read, write}, 3'b001);
    for (int i = 0; i < (TMO_EN ? 2 : 5); i++) step("wrhold", 0, 0, 0, 0);
    check("wrhold.lit", {idle, read, write}, 3'b001);
    step("wrack", 0, 0, 0, 1);
    check("wrack.lit", {idle, read, write}, 3'b100);

    // 4: read with req and ack held high passes through idle
    step("ch0", 0, 1, 0, 0);
    step("ch1", 0, 1, 0, 1);
    check("ch1.lit", {idle, read, write}, 3'b100);
    step("ch2", 0, 1, 0, 1);
    check("ch2.lit", {idle, read, write}, 3'b010);
    step("ch3", 0, 0, 0, 1);

    // 5: reset during write
    step("rw0", 0, 1, 1, 0);
    step("rw1", 1, 0, 0, 0);
    check("rw1.lit", {idle, read, write, timeout}, 4'b1000);
    step("rw2", 0, 0, 0, 0);

    // 6: timeout abort (with timeout disabled the read just keeps waiting)
    step("to0", 0, 1, 0, 0);
    for (int i = 0; i < T - 1; i++) step("to_wait", 0, 0, 0, 0);
    step("to_exp", 0, 0, 0, 0);
    if (TMO_EN) check("to_exp.lit", {idle, read, write, timeout}, 4'b1000);
    else        check("to_exp.lit", {idle, read, write, timeout}, 4'b0100);
    step("to_after", 0, 0, 0, TMO_EN ? 1'b0 : 1'b1);

    // ack exactly on the expiring cycle is a normal finish
    step("ae0", 0, 1, 1, 0);
    for (int i = 0; i < T - 1; i++) step("ae_wait", 0, 0, 0, 0);
    step("ae_ack", 0, 0, 0, 1);
    check("ae_ack.lit", {idle, read, write, timeout}, 4'b1000);

    // randomized traffic with sparse ack and rare reset
    for (int i = 0; i < 600; i++) begin
      step("rand",
           $urandom_range(0, 59) == 0,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 4) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
